// File: rtl/load_align_unit_pkg.sv
// load_pkg: shared types and decode helpers for the load alignment unit.
//   width_e  - load width/sign codes (bit2 set = zero-extend)
//   state_e  - FSM states of load_align_unit
//   size_of  - log2 of the access size in bytes
//   is_legal - whether a width code is usable for a given XLEN
package load_pkg;

  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;

  typedef enum logic [2:0] {
    W_W  = 3'b000,
    W_H  = 3'b010,
    W_HU = 3'b110,
    W_B  = 3'b001,
    W_BU = 3'b101,
    W_D  = 3'b011,
    W_WU = 3'b100
  } width_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } state_e;

  function automatic logic [1:0] size_of(input logic [2:0] w);
    case (w[1:0])
      2'b01:   return 2'd0;
      2'b10:   return 2'd1;
      2'b00:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] w);
    return w[2];
  endfunction

  function automatic logic is_legal(input logic [2:0] w, input int unsigned xlen);
    case (w)
      3'b000, 3'b010, 3'b110, 3'b001, 3'b101: return 1'b1;
      3'b011, 3'b100:                         return xlen == XLEN_64;
      default:                                return xlen < XLEN_32;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// load_align_unit_if: request, memory-beat and response signals of the load
// alignment unit.
//   slave  - the unit's view (takes requests, issues memory beats, returns results)
//   master - the surrounding pipeline/memory view
interface load_align_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 5
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_width;
  logic [TAG_W-1:0]  req_tag;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_fault;

  modport slave (
    input  req_valid, req_addr, req_width, req_tag,
           mem_req_ready, mem_rsp_valid, mem_rdata, rsp_ready,
    output req_ready, mem_req_valid, mem_addr,
           rsp_valid, rsp_data, rsp_tag, rsp_fault
  );

  modport master (
    output req_valid, req_addr, req_width, req_tag,
           mem_req_ready, mem_rsp_valid, mem_rdata, rsp_ready,
    input  req_ready, mem_req_valid, mem_addr,
           rsp_valid, rsp_data, rsp_tag, rsp_fault
  );
endinterface

// File: rtl/load_align_unit_extend.sv
// load_extend: combinational lane extraction for loads.
//   beats - {beat1, beat0}; beat1 is zero for single-beat loads
//   off   - byte offset of the load within beat0
//   width - width/sign code
//   data  - addressed bytes, sign- or zero-extended to XLEN
module load_extend
  import load_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0]         beats,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [2:0]                width,
  output logic [XLEN-1:0]           data
);
  localparam logic [XLEN-1:0] ONES = '1;

  logic [2*XLEN-1:0] shifted;
  logic [XLEN-1:0]   low;
  logic [XLEN-1:0]   mask;
  int unsigned       nbits;
  logic              fill;

  // mask covers the loaded field; mask ^ (mask >> 1) isolates its top bit
  always_comb begin
    shifted = beats >> {off, 3'b000};
    low     = shifted[XLEN-1:0];
    nbits   = 32'd8 << size_of(width);
    mask    = ~(ONES << nbits);
    fill    = !is_unsigned(width) && (|(low & (mask ^ (mask >> 1))));
    data    = (low & mask) | ({XLEN{fill}} & ~mask);
  end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: load-data alignment and extension between MEM stage and
// the data memory port.
//   clk, reset - clock and asynchronous active-high reset
//   bus        - load_align_unit_if.slave: req_* (load request), mem_* (aligned
//                memory beats), rsp_* (aligned/extended result, tag, fault)
// Misaligned loads crossing a beat boundary are split into two beats when
// MISALIGN_SPLIT_EN is defined; otherwise they return rsp_fault without any
// memory access.
module load_align_unit
  import load_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input logic              clk,
  input logic              reset,
  load_align_unit_if.slave bus
);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam logic [XLEN-1:0] ZERO = '0;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            state, state_n;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [OFF_W-1:0]  off_q;
  logic [2:0]        width_q;
  logic [TAG_W-1:0]  tag_q;
  logic              split_q;
  logic [XLEN-1:0]   beat0_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              rsp_fault_q;

  logic              req_split;
  logic              req_fault;
  logic [2*XLEN-1:0] ext_beats;
  logic [XLEN-1:0]   ext_data;

  always_comb begin
    req_split = (32'(bus.req_addr[OFF_W-1:0]) + (32'd1 << size_of(bus.req_width))) > NB;
    req_fault = !is_legal(bus.req_width, XLEN) || (req_split && !SPLIT_EN);
    // the result is extracted straight from the arriving beat so it can be
    // registered on entry to RESP
    ext_beats = (state == S_WAIT1) ? {bus.mem_rdata, beat0_q} : {ZERO, bus.mem_rdata};
  end

  load_extend #(.XLEN(XLEN)) u_extend (
    .beats (ext_beats),
    .off   (off_q),
    .width (width_q),
    .data  (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n           = state;
    bus.req_ready     = (state == S_IDLE);
    bus.mem_req_valid = (state == S_REQ0) || (state == S_REQ1);
    bus.rsp_valid     = (state == S_RESP);
    case (state)
      S_IDLE:  if (bus.req_valid)     state_n = req_fault ? S_RESP : S_REQ0;
      S_REQ0:  if (bus.mem_req_ready) state_n = S_WAIT0;
      S_WAIT0: if (bus.mem_rsp_valid) state_n = split_q ? S_REQ1 : S_RESP;
      S_REQ1:  if (bus.mem_req_ready) state_n = S_WAIT1;
      S_WAIT1: if (bus.mem_rsp_valid) state_n = S_RESP;
      S_RESP:  if (bus.rsp_ready)     state_n = S_IDLE;
      default:                        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= '0;
      off_q       <= '0;
      width_q     <= '0;
      tag_q       <= '0;
      split_q     <= 1'b0;
      beat0_q     <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          off_q      <= bus.req_addr[OFF_W-1:0];
          width_q    <= bus.req_width;
          tag_q      <= bus.req_tag;
          split_q    <= req_split;
          mem_addr_q <= bus.req_addr & ~ADDR_W'(NB - 1);
          if (req_fault) begin
            rsp_data_q  <= '0;
            rsp_tag_q   <= bus.req_tag;
            rsp_fault_q <= 1'b1;
          end
        end
        S_WAIT0: if (bus.mem_rsp_valid) begin
          beat0_q <= bus.mem_rdata;
          if (split_q) begin
            mem_addr_q <= mem_addr_q + ADDR_W'(NB);
          end else begin
            rsp_data_q  <= ext_data;
            rsp_tag_q   <= tag_q;
            rsp_fault_q <= 1'b0;
          end
        end
        S_WAIT1: if (bus.mem_rsp_valid) begin
          rsp_data_q  <= ext_data;
          rsp_tag_q   <= tag_q;
          rsp_fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

  localparam logic [2:0] LW = 3'b000, LH = 3'b010, LHU = 3'b110, LB = 3'b001,
                         LBU = 3'b101, LD = 3'b011, LWU = 3'b100, LBAD = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_align_unit_if #(.XLEN(32), .ADDR_W(32), .TAG_W(5)) b32 ();
  load_align_unit_if #(.XLEN(64), .ADDR_W(32), .TAG_W(5)) b64 ();

  load_align_unit #(.XLEN(32), .ADDR_W(32), .TAG_W(5)) u32 (.clk(clk), .reset(reset), .bus(b32));
  load_align_unit #(.XLEN(64), .ADDR_W(32), .TAG_W(5)) u64 (.clk(clk), .reset(reset), .bus(b64));

  // shared stimulus, steered to the selected DUT
  logic        sel64 = 1'b0;
  logic        r_req_valid = 1'b0;
  logic [31:0] r_req_addr = '0;
  logic [2:0]  r_req_width = '0;
  logic [4:0]  r_req_tag = '0;
  logic        r_mem_req_ready = 1'b0;
  logic        r_mem_rsp_valid = 1'b0;
  logic [63:0] r_mem_rdata = '0;
  logic        r_rsp_ready = 1'b0;

  assign b32.req_valid     = r_req_valid & ~sel64;
  assign b64.req_valid     = r_req_valid & sel64;
  assign b32.req_addr      = r_req_addr;
  assign b64.req_addr      = r_req_addr;
  assign b32.req_width     = r_req_width;
  assign b64.req_width     = r_req_width;
  assign b32.req_tag       = r_req_tag;
  assign b64.req_tag       = r_req_tag;
  assign b32.mem_req_ready = r_mem_req_ready;
  assign b64.mem_req_ready = r_mem_req_ready;
  assign b32.mem_rsp_valid = r_mem_rsp_valid & ~sel64;
  assign b64.mem_rsp_valid = r_mem_rsp_valid & sel64;
  assign b32.mem_rdata     = r_mem_rdata[31:0];
  assign b64.mem_rdata     = r_mem_rdata;
  assign b32.rsp_ready     = r_rsp_ready;
  assign b64.rsp_ready     = r_rsp_ready;

  logic        s_req_ready, s_mem_req_valid, s_rsp_valid, s_rsp_fault;
  logic [31:0] s_mem_addr;
  logic [63:0] s_rsp_data;
  logic [4:0]  s_rsp_tag;

  always_comb begin
    if (sel64) begin
      s_req_ready = b64.req_ready; s_mem_req_valid = b64.mem_req_valid;
      s_rsp_valid = b64.rsp_valid; s_rsp_fault = b64.rsp_fault;
      s_mem_addr  = b64.mem_addr;  s_rsp_data = b64.rsp_data; s_rsp_tag = b64.rsp_tag;
    end else begin
      s_req_ready = b32.req_ready; s_mem_req_valid = b32.mem_req_valid;
      s_rsp_valid = b32.rsp_valid; s_rsp_fault = b32.rsp_fault;
      s_mem_addr  = b32.mem_addr;  s_rsp_data = {32'd0, b32.rsp_data}; s_rsp_tag = b32.rsp_tag;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          wide;
    logic [31:0] addr;
    logic [2:0]  width;
    logic [63:0] rd0, rd1;
    logic [63:0] data;
    logic        fault;
    int unsigned nbeats;
    logic [31:0] a0, a1;
    int unsigned lat;
    int unsigned stall;
    int unsigned hold;
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [63:0] data;
    logic        fault;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  function automatic vec_t mk(bit wide, logic [31:0] addr, logic [2:0] w, logic [63:0] rd0,
                              logic [63:0] data, logic [31:0] a0, int unsigned stall, int unsigned hold);
    vec_t v;
    v.wide = wide; v.addr = addr; v.width = w; v.rd0 = rd0; v.rd1 = '0;
    v.data = data; v.fault = 1'b0; v.nbeats = 1; v.a0 = a0; v.a1 = '0;
    v.lat = 3 + stall; v.stall = stall; v.hold = hold;
    return v;
  endfunction

  function automatic vec_t flt(bit wide, logic [31:0] addr, logic [2:0] w);
    vec_t v;
    v = mk(wide, addr, w, '0, '0, '0, 0, 0);
    v.fault = 1'b1; v.nbeats = 0; v.lat = 1;
    return v;
  endfunction

  function automatic vec_t spl(bit wide, logic [31:0] addr, logic [2:0] w, logic [63:0] rd0,
                               logic [63:0] rd1, logic [63:0] data, logic [31:0] a0, logic [31:0] a1);
    vec_t v;
`ifdef MISALIGN_SPLIT_EN
    v = mk(wide, addr, w, rd0, data, a0, 0, 0);
    v.rd1 = rd1; v.a1 = a1; v.nbeats = 2; v.lat = 5;
`else
    v = flt(wide, addr, w);
`endif
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input logic [4:0] tag);
    int unsigned nreq = 0;
    int unsigned stall_left;
    int unsigned lat = 0;
    bit pend = 1'b0;
    bit pend_n;
    bit seen = 1'b0;
    exp_t e;
    sel64 = v.wide;
    r_req_addr = v.addr; r_req_width = v.width; r_req_tag = tag; r_req_valid = 1'b1;
    r_rsp_ready = 1'b0; stall_left = v.stall;
    sbq.push_back('{tag, v.data, v.fault});
    #1;
    chk("req_ready before accept", s_req_ready, 1);
    @(posedge clk); #1;
    r_req_valid = 1'b0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      r_mem_rsp_valid = pend;
      r_mem_rdata = pend ? ((nreq == 1) ? v.rd0 : v.rd1) : {$urandom, $urandom};
      if (s_rsp_valid) begin
        seen = 1'b1;
        lat = c;
      end else begin
        pend_n = 1'b0;
        if (s_mem_req_valid) begin
          chk("mem_addr", s_mem_addr, (nreq == 0) ? v.a0 : v.a1);
          if (stall_left > 0) begin
            stall_left--;
            r_mem_req_ready = 1'b0;
          end else begin
            r_mem_req_ready = 1'b1;
            nreq++;
            pend_n = 1'b1;
            stall_left = v.stall;
          end
        end
        @(posedge clk); #1;
        pend = pend_n;
      end
    end
    r_mem_rsp_valid = 1'b0;
    chk("rsp_valid within budget", seen, 1);
    chk("scoreboard nonempty", sbq.size() > 0, 1);
    if (sbq.size() > 0) e = sbq.pop_front();
    if (seen) begin
      chk("latency", lat, v.lat);
      chk("mem beats", nreq, v.nbeats);
      chk("rsp_data", s_rsp_data, e.data);
      chk("rsp_fault", s_rsp_fault, e.fault);
      chk("rsp_tag", s_rsp_tag, e.tag);
      for (int h = 0; h < int'(v.hold); h++) begin
        @(posedge clk); #1;
        chk("hold rsp_valid", s_rsp_valid, 1);
        chk("hold rsp_data", s_rsp_data, e.data);
        chk("hold rsp_tag", s_rsp_tag, e.tag);
        chk("hold req_ready", s_req_ready, 0);
      end
      r_rsp_ready = 1'b1;
      @(posedge clk); #1;
      r_rsp_ready = 1'b0;
      chk("rsp_valid drops", s_rsp_valid, 0);
      chk("req_ready returns", s_req_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(0, 32'h103, LB,  64'h80FF_7F01, 64'hFFFF_FF80, 32'h100, 0, 0));
    vecs.push_back(mk(0, 32'h102, LHU, 64'hBEEF_1234, 64'h0000_BEEF, 32'h100, 0, 0));
    vecs.push_back(mk(0, 32'h102, LH,  64'hBEEF_1234, 64'hFFFF_BEEF, 32'h100, 0, 0));
    vecs.push_back(mk(0, 32'h102, LBU, 64'h80FF_7F01, 64'h0000_00FF, 32'h100, 0, 0));
    vecs.push_back(mk(0, 32'h101, LB,  64'h80FF_7F01, 64'h0000_007F, 32'h100, 0, 0));
    vecs.push_back(mk(0, 32'h200, LW,  64'h1234_5678, 64'h1234_5678, 32'h200, 2, 0));
    vecs.push_back(mk(0, 32'h000, LH,  64'h0000_8001, 64'hFFFF_8001, 32'h000, 0, 0));
    vecs.push_back(flt(0, 32'h000, LD));
    vecs.push_back(flt(0, 32'h004, LWU));
    vecs.push_back(flt(0, 32'h008, LBAD));
    vecs.push_back(spl(0, 32'h0FF, LW, 64'hAA00_0000, 64'h0033_2211, 64'h3322_11AA, 32'h0FC, 32'h100));
    vecs.push_back(spl(0, 32'h002, LW, 64'h5566_7788, 64'h1122_3344, 64'h3344_5566, 32'h000, 32'h004));
    vecs.push_back(spl(0, 32'h003, LH, 64'hAB00_0000, 64'h0000_00CD, 64'hFFFF_CDAB, 32'h000, 32'h004));
    vecs.push_back(spl(0, 32'hFFFF_FFFE, LW, 64'h1234_0000, 64'h0000_5678, 64'h5678_1234,
                       32'hFFFF_FFFC, 32'h0000_0000));
    vecs.push_back(mk(1, 32'h004, LWU, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 32'h0, 0, 4));
    vecs.push_back(mk(1, 32'h004, LW,  64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h007, LB,  64'h8765_4321_0000_0000, 64'hFFFF_FFFF_FFFF_FF87, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h008, LD,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 32'h8, 0, 0));
    vecs.push_back(flt(1, 32'h000, LBAD));
    vecs.push_back(spl(1, 32'h004, LD, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                       64'h7777_8888_1111_2222, 32'h0, 32'h8));

    // reset state, with a request held during reset that must be ignored
    reset = 1'b1;
    r_req_valid = 1'b1; r_req_addr = 32'h103; r_req_width = LB; r_mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      sel64 = (w == 1);
      #1;
      chk("reset rsp_valid", s_rsp_valid, 0);
      chk("reset mem_req_valid", s_mem_req_valid, 0);
      chk("reset rsp_fault", s_rsp_fault, 0);
      chk("reset rsp_data", s_rsp_data, 0);
      chk("reset rsp_tag", s_rsp_tag, 0);
      chk("reset mem_addr", s_mem_addr, 0);
    end
    r_req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < 2; w++) begin
      sel64 = (w == 1);
      #1;
      chk("post-reset req_ready", s_req_ready, 1);
      chk("post-reset mem_req_valid", s_mem_req_valid, 0);
    end

    foreach (vecs[i]) run_vec(vecs[i], 5'(i + 1));

    // reset while waiting for beat0, then a stale response must be ignored
    sel64 = 1'b0;
    r_req_addr = 32'h103; r_req_width = LB; r_req_tag = 5'h1F;
    r_req_valid = 1'b1; r_mem_req_ready = 1'b1;
    @(posedge clk); #1;
    r_req_valid = 1'b0;
    chk("abort seq mem_req_valid", s_mem_req_valid, 1);
    @(posedge clk); #1;
    chk("abort seq in WAIT0", s_mem_req_valid, 0);
    reset = 1'b1;
    #1;
    chk("abort rsp_valid", s_rsp_valid, 0);
    chk("abort mem_addr", s_mem_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    r_mem_rsp_valid = 1'b1; r_mem_rdata = 64'h80FF_7F01;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stale rsp ignored", s_rsp_valid, 0);
      chk("stale no mem req", s_mem_req_valid, 0);
      chk("stale req_ready", s_req_ready, 1);
    end
    r_mem_rsp_valid = 1'b0;
    run_vec(mk(0, 32'h103, LB, 64'h80FF_7F01, 64'hFFFF_FF80, 32'h100, 0, 0), 5'h1E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
